// File: rtl/hazard_ctrl_md.sv
// Pipeline hazard unit: operand forwarding selects, load-use and mult/div
// stalls, the mult/div busy counter and a saturating stall-cycle counter.
module hazard_ctrl_md #(
   parameter int TW       = 2,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_D,
   input  logic [4:0]       rt_D,
   input  logic [TW-1:0]    tuse_rs_D,
   input  logic [TW-1:0]    tuse_rt_D,
   input  logic [4:0]       wr_E,
   input  logic [4:0]       wr_M,
   input  logic [4:0]       wr_W,
   input  logic [TW-1:0]    tnew_E,
   input  logic [TW-1:0]    tnew_M,
   input  logic [4:0]       rs_E,
   input  logic [4:0]       rt_E,
   input  logic             st_M,
   input  logic [4:0]       rt_M,
   input  logic             md_start_E,
   input  logic             md_div_E,
   input  logic             md_use_D,
   output logic [1:0]       fwd_rs_D,
   output logic [1:0]       fwd_rt_D,
   output logic [1:0]       fwd_rs_E,
   output logic [1:0]       fwd_rt_E,
   output logic             fwd_wd_M,
   output logic             pc_en,
   output logic             ifd_en,
   output logic             flush_DE,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [TW-1:0] NOT_USED = '1;
   localparam logic [3:0]    MULT_L   = 4'(MULT_LAT);
   localparam logic [3:0]    DIV_L    = 4'(DIV_LAT);

   logic [3:0] md_cnt;
   logic       rs_stall;
   logic       rt_stall;
   logic       data_stall;
   logic       md_stall;
   logic       stall;

   // D-stage bypass: the youngest producer whose result already exists wins.
   assign fwd_rs_D = (rs_D == 5'd0)                     ? 2'd0 :
                     (rs_D == wr_E && tnew_E == '0)     ? 2'd1 :
                     (rs_D == wr_M && tnew_M == '0)     ? 2'd2 :
                     (rs_D == wr_W)                     ? 2'd3 : 2'd0;
   assign fwd_rt_D = (rt_D == 5'd0)                     ? 2'd0 :
                     (rt_D == wr_E && tnew_E == '0)     ? 2'd1 :
                     (rt_D == wr_M && tnew_M == '0)     ? 2'd2 :
                     (rt_D == wr_W)                     ? 2'd3 : 2'd0;

   assign fwd_rs_E = (rs_E == 5'd0)                     ? 2'd0 :
                     (rs_E == wr_M && tnew_M == '0)     ? 2'd1 :
                     (rs_E == wr_W)                     ? 2'd2 : 2'd0;
   assign fwd_rt_E = (rt_E == 5'd0)                     ? 2'd0 :
                     (rt_E == wr_M && tnew_M == '0)     ? 2'd1 :
                     (rt_E == wr_W)                     ? 2'd2 : 2'd0;

   assign fwd_wd_M = st_M && (rt_M == wr_W) && (wr_W != 5'd0);

   // A source stalls only if its producer finishes later than D needs it.
   assign rs_stall = (rs_D != 5'd0) && (tuse_rs_D != NOT_USED) &&
                     (((rs_D == wr_E) && (tuse_rs_D < tnew_E)) ||
                      ((rs_D == wr_M) && (tuse_rs_D < tnew_M)));
   assign rt_stall = (rt_D != 5'd0) && (tuse_rt_D != NOT_USED) &&
                     (((rt_D == wr_E) && (tuse_rt_D < tnew_E)) ||
                      ((rt_D == wr_M) && (tuse_rt_D < tnew_M)));

   assign data_stall = rs_stall || rt_stall;
   assign md_stall   = md_use_D && (md_busy || md_start_E);
   assign stall      = data_stall || md_stall;

   assign pc_en    = !stall;
   assign ifd_en   = !stall;
   assign flush_DE = stall;

   assign md_busy = (md_cnt != 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt <= 4'd0;
      end else if (md_start_E) begin
         md_cnt <= md_div_E ? DIV_L : MULT_L;
      end else if (md_cnt != 4'd0) begin
         md_cnt <= md_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Directed-vector bench for hazard_ctrl_md; a second instance with a 4-bit
// stall counter shares the same inputs to exercise saturation.
module tb_hazard_ctrl_md;

   localparam int W = 33;

   logic       clk;
   logic       reset;
   logic [4:0] rs_D, rt_D, wr_E, wr_M, wr_W, rs_E, rt_E, rt_M;
   logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
   logic       st_M, md_start_E, md_div_E, md_use_D;

   logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
   logic        fwd_wd_M, pc_en, ifd_en, flush_DE, md_busy;
   logic [15:0] stall_cnt;

   logic [1:0]  s_fwd_rs_D, s_fwd_rt_D, s_fwd_rs_E, s_fwd_rt_E;
   logic        s_fwd_wd_M, s_pc_en, s_ifd_en, s_flush_DE, s_md_busy;
   logic [3:0]  s_stall_cnt;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_vec;
   int           n_fail;
   int           exp_stall;

   hazard_ctrl_md dut (
      .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
      .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
      .wr_E(wr_E), .wr_M(wr_M), .wr_W(wr_W), .tnew_E(tnew_E), .tnew_M(tnew_M),
      .rs_E(rs_E), .rt_E(rt_E), .st_M(st_M), .rt_M(rt_M),
      .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
      .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
      .fwd_rt_E(fwd_rt_E), .fwd_wd_M(fwd_wd_M), .pc_en(pc_en), .ifd_en(ifd_en),
      .flush_DE(flush_DE), .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   hazard_ctrl_md #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
      .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
      .wr_E(wr_E), .wr_M(wr_M), .wr_W(wr_W), .tnew_E(tnew_E), .tnew_M(tnew_M),
      .rs_E(rs_E), .rt_E(rt_E), .st_M(st_M), .rt_M(rt_M),
      .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
      .fwd_rs_D(s_fwd_rs_D), .fwd_rt_D(s_fwd_rt_D), .fwd_rs_E(s_fwd_rs_E),
      .fwd_rt_E(s_fwd_rt_E), .fwd_wd_M(s_fwd_wd_M), .pc_en(s_pc_en),
      .ifd_en(s_ifd_en), .flush_DE(s_flush_DE), .md_busy(s_md_busy),
      .stall_cnt(s_stall_cnt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: one expected record per driven vector, compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         logic [W-1:0] a;
         string        n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_wd_M, pc_en, ifd_en,
              flush_DE, md_busy, stall_cnt, s_stall_cnt};
         n_vec++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_sig(input string nm, input logic [15:0] got,
                             input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic set_idle();
      rs_D = 0; rt_D = 0; tuse_rs_D = 2'b11; tuse_rt_D = 2'b11;
      wr_E = 0; wr_M = 0; wr_W = 0; tnew_E = 0; tnew_M = 0;
      rs_E = 0; rt_E = 0; st_M = 0; rt_M = 0;
      md_start_E = 0; md_div_E = 0; md_use_D = 0;
   endtask

   // Push the hand-computed response for the inputs currently applied.
   task automatic check(input string nm, input logic [1:0] e_rs_d,
                        input logic [1:0] e_rt_d, input logic [1:0] e_rs_e,
                        input logic [1:0] e_rt_e, input logic e_wd,
                        input logic e_stall, input logic e_busy);
      logic [3:0] sat;
      sat = (exp_stall > 15) ? 4'hf : 4'(exp_stall);
      exp_q.push_back({e_rs_d, e_rt_d, e_rs_e, e_rt_e, e_wd, !e_stall, !e_stall,
                       e_stall, e_busy, 16'(exp_stall), sat});
      name_q.push_back(nm);
      if (reset) exp_stall = 0;
      else if (e_stall) exp_stall++;
      step();
   endtask

   initial begin
      n_vec = 0; n_fail = 0; exp_stall = 0;
      reset = 1'b1;
      set_idle();
      step();
      check("reset_state", 0, 0, 0, 0, 0, 0, 0);
      expect_sig("reset_md_busy", 16'(md_busy), 16'd0);
      expect_sig("reset_stall_cnt", stall_cnt, 16'd0);
      expect_sig("reset_pc_en", 16'(pc_en), 16'd1);
      expect_sig("reset_flush_DE", 16'(flush_DE), 16'd0);
      reset = 1'b0;
      check("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);

      wr_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1;
      check("load_use", 0, 0, 0, 0, 0, 1, 0);
      set_idle();
      check("load_use_cnt", 0, 0, 0, 0, 0, 0, 0);

      wr_E = 9; wr_M = 9; wr_W = 9; tnew_E = 0; tnew_M = 0; rt_D = 9; tuse_rt_D = 0;
      check("fwd_prio_E", 0, 1, 0, 0, 0, 0, 0);
      tnew_E = 1; tuse_rt_D = 1;
      check("fwd_prio_M", 0, 2, 0, 0, 0, 0, 0);

      set_idle();
      wr_M = 5; wr_W = 6; rs_E = 5; rt_E = 6; st_M = 1; rt_M = 6;
      check("fwd_E_and_store", 0, 0, 1, 2, 1, 0, 0);

      set_idle();
      wr_M = 5; tnew_M = 1; wr_W = 5; rs_E = 5; rs_D = 5; tuse_rs_D = 0;
      check("m_not_ready", 3, 0, 2, 0, 0, 1, 0);

      set_idle();
      wr_E = 0; tnew_E = 2; rs_D = 0; tuse_rs_D = 0; st_M = 1; rt_M = 0;
      check("reg_zero", 0, 0, 0, 0, 0, 0, 0);

      set_idle();
      wr_E = 7; tnew_E = 3; rs_D = 7; tuse_rs_D = 3;
      check("tuse_not_used", 0, 0, 0, 0, 0, 0, 0);
      tuse_rs_D = 3; rt_D = 7; tuse_rt_D = 2;
      check("rt_stall", 0, 0, 0, 0, 0, 1, 0);

      set_idle();
      md_start_E = 1; md_div_E = 1; md_use_D = 1;
      check("div_start", 0, 0, 0, 0, 0, 1, 0);
      md_start_E = 0; md_div_E = 0;
      for (int i = 1; i <= 10; i++) check($sformatf("div_busy_%0d", i), 0, 0, 0, 0, 0, 1, 1);
      check("div_done", 0, 0, 0, 0, 0, 0, 0);
      expect_sig("div_expired_md_busy", 16'(md_busy), 16'd0);
      expect_sig("div_expired_pc_en", 16'(pc_en), 16'd1);
      expect_sig("div_expired_flush_DE", 16'(flush_DE), 16'd0);

      set_idle();
      md_start_E = 1;
      check("mult_start", 0, 0, 0, 0, 0, 0, 0);
      md_start_E = 0;
      check("mult_busy_1", 0, 0, 0, 0, 0, 0, 1);
      check("mult_busy_2", 0, 0, 0, 0, 0, 0, 1);
      reset = 1; md_start_E = 1;
      check("reset_mid_mult", 0, 0, 0, 0, 0, 0, 1);
      reset = 0; md_start_E = 0;
      check("after_reset_mid", 0, 0, 0, 0, 0, 0, 0);

      md_start_E = 1;
      check("restart_mult", 0, 0, 0, 0, 0, 0, 0);
      md_start_E = 0;
      check("restart_busy", 0, 0, 0, 0, 0, 0, 1);
      md_start_E = 1; md_div_E = 1;
      check("restart_div", 0, 0, 0, 0, 0, 0, 1);
      md_start_E = 0; md_div_E = 0;
      for (int i = 1; i <= 10; i++) check($sformatf("restart_busy_%0d", i), 0, 0, 0, 0, 0, 0, 1);
      check("restart_done", 0, 0, 0, 0, 0, 0, 0);

      wr_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1;
      for (int i = 0; i < 20; i++) check($sformatf("sat_%0d", i), 0, 0, 0, 0, 0, 1, 0);
      set_idle();
      check("sat_final", 0, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
